// File: rtl/multiplicator_arbiter.sv
// multiplicator_arbiter: shares one sequential multiplier between N_REQ
// requesters with round-robin arbitration. It captures the winner's operands,
// drives the multiplier's start/reset, and returns product/overflow with a
// one-cycle valid pulse. A watchdog aborts and resets the multiplier when done
// never arrives.
//
// Ports:
//   clock, reset_in        clock (rising edge), async active-high reset
//   req_in                 per-requester request level
//   multiplicand_in        requester i operand at [i*WIDTH +: WIDTH]
//   multiplier_in          requester i operand at [i*WIDTH +: WIDTH]
//   grant_out              one-hot current owner, 0 when idle
//   result_valid_out       one-hot one-cycle result pulse
//   product_out            result product, held until the next result
//   overflow_out           result overflow, held with product_out
//   timeout_out            one-cycle pulse with result_valid_out on abort
//   mul_multiplicand_out   operand to the multiplier
//   mul_multiplier_out     operand to the multiplier
//   mul_start_out          level start to the multiplier
//   mul_reset_out          reset to the multiplier
//   mul_done_in            done from the multiplier
//   mul_product_in         product from the multiplier
//   mul_overflow_in        overflow from the multiplier
module multiplicator_arbiter #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                     clock,
  input  logic                     reset_in,
  input  logic [N_REQ-1:0]         req_in,
  input  logic [N_REQ*WIDTH-1:0]   multiplicand_in,
  input  logic [N_REQ*WIDTH-1:0]   multiplier_in,
  output logic [N_REQ-1:0]         grant_out,
  output logic [N_REQ-1:0]         result_valid_out,
  output logic [2*WIDTH-1:0]       product_out,
  output logic                     overflow_out,
  output logic                     timeout_out,
  output logic [WIDTH-1:0]         mul_multiplicand_out,
  output logic [WIDTH-1:0]         mul_multiplier_out,
  output logic                     mul_start_out,
  output logic                     mul_reset_out,
  input  logic                     mul_done_in,
  input  logic [2*WIDTH-1:0]       mul_product_in,
  input  logic                     mul_overflow_in
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]  rr_ptr, rr_ptr_next;
  logic              done_prev;
  logic [WD_W-1:0]   watchdog, watchdog_next;
  logic              recover_cnt, recover_cnt_next;

  logic [N_REQ-1:0]  grant_next;
  logic [N_REQ-1:0]  result_valid_next;
  logic [PROD_W-1:0] product_next;
  logic              overflow_next;
  logic              timeout_next;
  logic [WIDTH-1:0]  mul_a_next;
  logic [WIDTH-1:0]  mul_b_next;
  logic              mul_start_next;
  logic              mul_reset_next;

  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [N_REQ-1:0]  win_onehot;
  logic [WIDTH-1:0]  win_a;
  logic [WIDTH-1:0]  win_b;
  logic              launch;
  logic              done_rise;

  // First set request searching upward from rr_ptr, wrapping at N_REQ.
  always_comb begin : rr_search
    int unsigned cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && req_in[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Winner one-hot and operand slice selection.
  always_comb begin : win_mux
    win_onehot = '0;
    win_a      = '0;
    win_b      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_onehot[i] = 1'b1;
        win_a         = multiplicand_in[i*WIDTH +: WIDTH];
        win_b         = multiplier_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // A stale done from the previous job blocks a new launch.
  assign launch    = win_found && !mul_done_in;
  assign done_rise = mul_done_in && !done_prev;

  // State and all registered outputs.
  always_ff @(posedge clock or posedge reset_in) begin : state_reg
    if (reset_in) begin
      state                <= ST_IDLE;
      rr_ptr               <= '0;
      done_prev            <= 1'b0;
      watchdog             <= '0;
      recover_cnt          <= 1'b0;
      grant_out            <= '0;
      result_valid_out     <= '0;
      product_out          <= '0;
      overflow_out         <= 1'b0;
      timeout_out          <= 1'b0;
      mul_multiplicand_out <= '0;
      mul_multiplier_out   <= '0;
      mul_start_out        <= 1'b0;
      mul_reset_out        <= 1'b1;
    end else begin
      state                <= state_next;
      rr_ptr               <= rr_ptr_next;
      done_prev            <= mul_done_in;
      watchdog             <= watchdog_next;
      recover_cnt          <= recover_cnt_next;
      grant_out            <= grant_next;
      result_valid_out     <= result_valid_next;
      product_out          <= product_next;
      overflow_out         <= overflow_next;
      timeout_out          <= timeout_next;
      mul_multiplicand_out <= mul_a_next;
      mul_multiplier_out   <= mul_b_next;
      mul_start_out        <= mul_start_next;
      mul_reset_out        <= mul_reset_next;
    end
  end

  // Next-state logic; done takes priority over the watchdog.
  always_comb begin : next_state_logic
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (launch) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise)               state_next = ST_RESPOND;
        else if (watchdog == WD_LAST) state_next = ST_RECOVER;
      end
      ST_RESPOND: state_next = ST_IDLE;
      ST_RECOVER: begin
        if (recover_cnt) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin : output_logic
    rr_ptr_next       = rr_ptr;
    watchdog_next     = watchdog;
    recover_cnt_next  = recover_cnt;
    grant_next        = grant_out;
    result_valid_next = result_valid_out;
    product_next      = product_out;
    overflow_next     = overflow_out;
    timeout_next      = timeout_out;
    mul_a_next        = mul_multiplicand_out;
    mul_b_next        = mul_multiplier_out;
    mul_start_next    = mul_start_out;
    mul_reset_next    = mul_reset_out;
    case (state)
      ST_IDLE: begin
        mul_reset_next    = 1'b0;
        result_valid_next = '0;
        timeout_next      = 1'b0;
        if (launch) begin
          grant_next     = win_onehot;
          mul_a_next     = win_a;
          mul_b_next     = win_b;
          mul_start_next = 1'b1;
          watchdog_next  = '0;
          rr_ptr_next    = (win_idx == IDX_LAST) ? '0 : win_idx + IDX_W'(1);
        end
      end
      ST_WAIT: begin
        if (done_rise) begin
          product_next      = mul_product_in;
          overflow_next     = mul_overflow_in;
          result_valid_next = grant_out;
          mul_start_next    = 1'b0;
        end else if (watchdog == WD_LAST) begin
          result_valid_next = grant_out;
          timeout_next      = 1'b1;
          product_next      = '0;
          overflow_next     = 1'b0;
          mul_start_next    = 1'b0;
          mul_reset_next    = 1'b1;
          recover_cnt_next  = 1'b0;
        end else begin
          watchdog_next = watchdog + WD_W'(1);
        end
      end
      ST_RESPOND: begin
        result_valid_next = '0;
        grant_next        = '0;
      end
      ST_RECOVER: begin
        // mul_reset_out stays high for this cycle and the next one.
        result_valid_next = '0;
        timeout_next      = 1'b0;
        grant_next        = '0;
        if (recover_cnt) mul_reset_next   = 1'b0;
        else             recover_cnt_next = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multiplicator_arbiter.sv
// Bench for multiplicator_arbiter: behavioural multiplier stand-in, a
// transaction-level reference model checked every cycle, directed scenarios
// with literal expectations, then randomized requester traffic.
module tb_multiplicator_arbiter;

  localparam int unsigned WIDTH          = 8;
  localparam int unsigned N_REQ          = 4;
  localparam int unsigned TIMEOUT_CYCLES = 64;
  localparam int unsigned PW             = 2 * WIDTH;

  logic                   clock = 1'b0;
  logic                   reset_in = 1'b1;
  logic [N_REQ-1:0]       req_in = '0;
  logic [N_REQ*WIDTH-1:0] multiplicand_in = '0;
  logic [N_REQ*WIDTH-1:0] multiplier_in = '0;
  logic [N_REQ-1:0]       grant_out;
  logic [N_REQ-1:0]       result_valid_out;
  logic [PW-1:0]          product_out;
  logic                   overflow_out;
  logic                   timeout_out;
  logic [WIDTH-1:0]       mul_multiplicand_out;
  logic [WIDTH-1:0]       mul_multiplier_out;
  logic                   mul_start_out;
  logic                   mul_reset_out;
  logic                   mul_done_in = 1'b0;
  logic [PW-1:0]          mul_product_in = '0;
  logic                   mul_overflow_in = 1'b0;

  int checks = 0;
  int errors = 0;

  multiplicator_arbiter #(
    .WIDTH(WIDTH), .N_REQ(N_REQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock), .reset_in(reset_in), .req_in(req_in),
    .multiplicand_in(multiplicand_in), .multiplier_in(multiplier_in),
    .grant_out(grant_out), .result_valid_out(result_valid_out),
    .product_out(product_out), .overflow_out(overflow_out),
    .timeout_out(timeout_out),
    .mul_multiplicand_out(mul_multiplicand_out),
    .mul_multiplier_out(mul_multiplier_out),
    .mul_start_out(mul_start_out), .mul_reset_out(mul_reset_out),
    .mul_done_in(mul_done_in), .mul_product_in(mul_product_in),
    .mul_overflow_in(mul_overflow_in)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Multiplier stand-in: level start, done after lat cycles, done held
  // while start stays high; withhold suppresses done entirely.
  int            lat = 2;
  bit            withhold = 1'b0;
  int            mcnt = 0;
  logic [PW-1:0] mprod;
  always @(posedge clock) begin
    if (mul_reset_out) begin
      mcnt = 0;
      mul_done_in     <= 1'b0;
      mul_product_in  <= '0;
      mul_overflow_in <= 1'b0;
    end else if (mul_start_out) begin
      if (!withhold && !mul_done_in) begin
        if (mcnt >= lat) begin
          mprod = PW'(mul_multiplicand_out) * PW'(mul_multiplier_out);
          mul_done_in     <= 1'b1;
          mul_product_in  <= mprod;
          mul_overflow_in <= |mprod[PW-1:WIDTH];
        end else begin
          mcnt++;
        end
      end
    end else begin
      mcnt = 0;
      mul_done_in <= 1'b0;
    end
  end

  // Reference model: owner/blocked-cycle bookkeeping driven by the
  // request, done-edge and watchdog rules; e_* are the expected outputs.
  logic [N_REQ-1:0] e_grant, e_rv;
  logic [PW-1:0]    e_prod;
  logic             e_ovf, e_to, e_start, e_mrst;
  logic [WIDTH-1:0] e_ma, e_mb;
  int               m_ptr, m_block, m_wait, mw;
  bit               m_busy, m_prev_done, m_rise;

  always @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      e_grant = '0; e_rv = '0; e_prod = '0; e_ovf = 1'b0; e_to = 1'b0;
      e_ma = '0; e_mb = '0; e_start = 1'b0; e_mrst = 1'b1;
      m_ptr = 0; m_block = 0; m_wait = 0; m_busy = 1'b0; m_prev_done = 1'b0;
    end else begin
      m_rise      = mul_done_in && !m_prev_done;
      m_prev_done = mul_done_in;
      if (m_block > 0) begin
        // cycles after a result during which nobody can be granted
        m_block--;
        e_rv = '0; e_to = 1'b0; e_grant = '0;
        e_mrst = (m_block > 0);
      end else if (m_busy) begin
        m_wait++;
        if (m_rise) begin
          e_prod = mul_product_in; e_ovf = mul_overflow_in;
          e_rv = e_grant; e_start = 1'b0; m_busy = 1'b0; m_block = 1;
        end else if (m_wait == TIMEOUT_CYCLES) begin
          e_rv = e_grant; e_to = 1'b1; e_prod = '0; e_ovf = 1'b0;
          e_start = 1'b0; e_mrst = 1'b1; m_busy = 1'b0; m_block = 2;
        end
      end else begin
        e_mrst = 1'b0; e_rv = '0; e_to = 1'b0;
        if (req_in != '0 && !mul_done_in) begin
          mw = -1;
          for (int k = 0; k < N_REQ; k++)
            if (mw < 0 && req_in[(m_ptr + k) % N_REQ]) mw = (m_ptr + k) % N_REQ;
          e_grant = '0; e_grant[mw] = 1'b1;
          e_ma = multiplicand_in[mw*WIDTH +: WIDTH];
          e_mb = multiplier_in[mw*WIDTH +: WIDTH];
          e_start = 1'b1; m_busy = 1'b1; m_wait = 0;
          m_ptr = (mw + 1) % N_REQ;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  bit cmp_en = 1'b0;
  always @(negedge clock) begin
    if (cmp_en) begin
      check("grant_out", grant_out, e_grant);
      check("result_valid_out", result_valid_out, e_rv);
      check("product_out", product_out, e_prod);
      check("overflow_out", overflow_out, e_ovf);
      check("timeout_out", timeout_out, e_to);
      check("mul_multiplicand_out", mul_multiplicand_out, e_ma);
      check("mul_multiplier_out", mul_multiplier_out, e_mb);
      check("mul_start_out", mul_start_out, e_start);
      check("mul_reset_out", mul_reset_out, e_mrst);
    end
  end

  // Start must stay low at least two cycles between jobs.
  int low_run = 0;
  bit had_job = 1'b0;
  always @(negedge clock) begin
    if (reset_in) begin
      low_run = 0; had_job = 1'b0;
    end else if (mul_start_out) begin
      if (had_job && low_run > 0) check("start_gap_ge2", 64'(low_run >= 2), 64'd1);
      low_run = 0; had_job = 1'b1;
    end else begin
      low_run++;
    end
  end

  logic [WIDTH-1:0] op_a [N_REQ];
  logic [WIDTH-1:0] op_b [N_REQ];

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    multiplicand_in[i*WIDTH +: WIDTH] = a;
    multiplier_in[i*WIDTH +: WIDTH]   = b;
    op_a[i] = a; op_b[i] = b;
    req_in[i] = 1'b1;
  endtask

  // Returns at the negedge where a result pulse is visible; idx=-1 on expiry.
  task automatic wait_any_rv(output int idx);
    bit got;
    got = 1'b0; idx = -1;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clock);
      if (result_valid_out != '0) begin
        got = 1'b1;
        for (int i = 0; i < N_REQ; i++) if (result_valid_out[i]) idx = i;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL wait_result: no result_valid_out within 400 cycles");
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return WIDTH'($urandom);
    endcase
  endfunction

  int idx, n;
  bit seen;

  initial begin
    for (int i = 0; i < N_REQ; i++) begin op_a[i] = '0; op_b[i] = '0; end
    @(posedge clock);
    cmp_en = 1'b1;

    // reset state
    @(negedge clock);
    check("rst_mul_reset", mul_reset_out, 1);
    check("rst_grant", grant_out, 0);
    check("rst_start", mul_start_out, 0);
    check("rst_product", product_out, 0);

    // single request 12*11
    #1 reset_in = 1'b0;
    lat = 3;
    set_req(0, 8'd12, 8'd11);
    @(negedge clock);
    check("t1_start", mul_start_out, 1);
    check("t1_grant", grant_out, 4'b0001);
    check("t1_mul_reset_low", mul_reset_out, 0);
    wait_any_rv(idx);
    check("t1_rv_idx", idx, 0);
    check("t1_product", product_out, 16'd132);
    check("t1_overflow", overflow_out, 0);
    req_in[0] = 1'b0;
    @(negedge clock);
    check("t1_rv_pulse", result_valid_out, 0);
    check("t1_product_held", product_out, 16'd132);

    // all four from reset: order 0..3, products (i+2)*(i+3)
    #1 reset_in = 1'b1;
    @(negedge clock);
    for (int i = 0; i < N_REQ; i++) set_req(i, WIDTH'(i + 2), WIDTH'(i + 3));
    #1 reset_in = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      wait_any_rv(idx);
      check("t2_order", idx, j);
      check("t2_product", product_out, (j + 2) * (j + 3));
      if (idx >= 0) req_in[idx] = 1'b0;
    end

    // round-robin wrap: after serving 2, 0101 grants 0 first
    lat = 1;
    @(negedge clock);
    set_req(2, 8'd7, 8'd9);
    wait_any_rv(idx);
    check("t3_first_idx", idx, 2);
    check("t3_first_product", product_out, 16'd63);
    req_in[2] = 1'b0;
    @(negedge clock);
    set_req(0, 8'd3, 8'd4);
    set_req(2, 8'd5, 8'd6);
    wait_any_rv(idx);
    check("t3_wrap_idx", idx, 0);
    check("t3_wrap_product", product_out, 16'd12);
    if (idx >= 0) req_in[idx] = 1'b0;
    wait_any_rv(idx);
    check("t3_second_idx", idx, 2);
    check("t3_second_product", product_out, 16'd30);
    if (idx >= 0) req_in[idx] = 1'b0;

    // max operands
    @(negedge clock);
    set_req(1, 8'd255, 8'd255);
    wait_any_rv(idx);
    check("t4_idx", idx, 1);
    check("t4_product", product_out, 16'hFE01);
    check("t4_overflow", overflow_out, 1);
    req_in[1] = 1'b0;

    // watchdog: done withheld, req 1 queued behind it
    withhold = 1'b1;
    @(negedge clock);
    set_req(3, 8'd10, 8'd20);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (mul_start_out && grant_out == 4'b1000) seen = 1'b1;
    end
    check("t5_launched", seen, 1);
    set_req(1, 8'd6, 8'd7);
    n = 1; seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clock);
      if (timeout_out) seen = 1'b1;
      else if (mul_start_out) n++;
    end
    check("t5_timeout_seen", seen, 1);
    check("t5_wait_cycles", n, TIMEOUT_CYCLES);
    check("t5_rv", result_valid_out, 4'b1000);
    check("t5_product_zero", product_out, 0);
    check("t5_mul_reset_1", mul_reset_out, 1);
    req_in[3] = 1'b0;
    withhold = 1'b0;
    @(negedge clock);
    check("t5_mul_reset_2", mul_reset_out, 1);
    check("t5_timeout_pulse", timeout_out, 0);
    check("t5_rv_pulse", result_valid_out, 0);
    @(negedge clock);
    check("t5_mul_reset_off", mul_reset_out, 0);
    wait_any_rv(idx);
    check("t5_next_idx", idx, 1);
    check("t5_next_product", product_out, 16'd42);
    req_in[1] = 1'b0;

    // async reset while waiting
    lat = 10;
    @(negedge clock);
    set_req(0, 8'd2, 8'd2);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (grant_out != '0) seen = 1'b1;
    end
    check("t6_granted", seen, 1);
    @(posedge clock);
    #1 reset_in = 1'b1;
    #1;
    check("t6_grant", grant_out, 0);
    check("t6_rv", result_valid_out, 0);
    check("t6_start", mul_start_out, 0);
    check("t6_mul_reset", mul_reset_out, 1);
    check("t6_product", product_out, 0);
    req_in = '0;
    repeat (2) @(negedge clock);
    #1 reset_in = 1'b0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (!mul_start_out) begin
        lat      = $urandom_range(0, 5);
        withhold = ($urandom_range(0, 15) == 0);
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_in[i] && result_valid_out[i]) begin
          if (!timeout_out) check("rand_product", product_out, PW'(op_a[i]) * PW'(op_b[i]));
          req_in[i] = 1'b0;
        end else if (!req_in[i] && $urandom_range(0, 3) == 0) begin
          set_req(i, rand_op(), rand_op());
        end else if (req_in[i] && !grant_out[i] && $urandom_range(0, 99) == 0) begin
          req_in[i] = 1'b0;
        end
      end
    end

    req_in = '0;
    withhold = 1'b0;
    repeat (100) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
